// File: rtl/atp_pkg.sv
// Shared types and note values for the bill-payment kiosk controller.
package atp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReadCard,
        StPinEntry,
        StPayment,
        StSuccess,
        StFail,
        StTimeout
    } state_e;

    // Note values expressed in Rs-50 units.
    localparam int unsigned UNITS_1000 = 20;
    localparam int unsigned UNITS_500  = 10;
    localparam int unsigned UNITS_100  = 2;
    localparam int unsigned UNITS_50   = 1;
    localparam int unsigned PAID_MAX   = 255;

    // edges = {1000, 500, 100, 50}; simultaneous notes are summed.
    function automatic logic [8:0] note_units(input logic [3:0] edges);
        logic [8:0] total;
        total = 9'd0;
        if (edges[3]) total = total + 9'(UNITS_1000);
        if (edges[2]) total = total + 9'(UNITS_500);
        if (edges[1]) total = total + 9'(UNITS_100);
        if (edges[0]) total = total + 9'(UNITS_50);
        return total;
    endfunction

endpackage

// File: rtl/atp_coin_accumulator.sv
// Rising-edge detectors on the four note inputs and a saturating running total.
module atp_coin_accumulator
    import atp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       payment_1000,
    input  logic       payment_500,
    input  logic       payment_100,
    input  logic       payment_50,
    output logic [7:0] paid,
    output logic [7:0] paid_next,
    output logic       edge_seen
);

    logic [3:0] notes;
    logic [3:0] hist_q;
    logic [3:0] edges;
    logic [7:0] paid_q;
    logic [7:0] paid_d;
    logic [8:0] sum;

    assign notes     = {payment_1000, payment_500, payment_100, payment_50};
    assign edges     = notes & ~hist_q;
    assign edge_seen = |edges;

    always_comb begin
        sum    = {1'b0, paid_q} + note_units(edges);
        paid_d = paid_q;
        if (clear) begin
            paid_d = 8'd0;
        end else if (enable) begin
            paid_d = (sum > 9'(PAID_MAX)) ? 8'(PAID_MAX) : sum[7:0];
        end
    end

    // History runs in every state so a note held high on entry is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= 4'd0;
            paid_q <= 8'd0;
        end else begin
            hist_q <= notes;
            paid_q <= paid_d;
        end
    end

    assign paid      = paid_q;
    assign paid_next = paid_d;

endmodule

// File: rtl/atp_machine_electricity_bill_payment.sv
// Bill-payment kiosk controller: card read, PIN check, note accumulation, result flags.
// Define ATP_PIN_TIMEOUT_EN to also time out an idle PIN entry.
module atp_machine_electricity_bill_payment
    import atp_pkg::*;
#(
    parameter logic [3:0]  PIN_CODE       = 4'b1010,
    parameter int unsigned BILL_UNITS     = 33,
    parameter int unsigned TIMEOUT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       card_inserted,
    input  logic [7:0] card_data,
    input  logic [3:0] pin,
    input  logic       payment_1000,
    input  logic       payment_500,
    input  logic       payment_100,
    input  logic       payment_50,
    output logic [7:0] display,
    output logic       payment_success,
    output logic       payment_fail,
    output logic       payment_timeout
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 2);

    state_e            state_q, state_d;
    logic [7:0]        card_id_q, card_id_d;
    logic              card_prev_q;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [7:0]        display_q, display_d;
    logic              success_q, fail_q, timeout_q;

    logic              card_rise;
    logic              timeout_hit;
    logic              paid_done;
    logic              clear_paid;
    logic              acc_enable;
    logic [7:0]        paid;
    logic [7:0]        paid_next;
    logic              edge_seen;

    assign card_rise   = card_inserted & ~card_prev_q;
    assign timeout_hit = (cnt_q == CntW'(TIMEOUT_CYCLES));
    assign paid_done   = ({1'b0, paid} >= 9'(BILL_UNITS));
    assign acc_enable  = (state_q == StPayment);

    atp_coin_accumulator u_acc (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear_paid),
        .enable       (acc_enable),
        .payment_1000 (payment_1000),
        .payment_500  (payment_500),
        .payment_100  (payment_100),
        .payment_50   (payment_50),
        .paid         (paid),
        .paid_next    (paid_next),
        .edge_seen    (edge_seen)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (card_inserted) state_d = StReadCard;
            end
            StReadCard: begin
                if (!card_inserted) state_d = StPinEntry;
            end
            StPinEntry: begin
                if (card_rise) begin
                    state_d = StReadCard;
                end else if (pin != 4'd0) begin
                    state_d = (pin == PIN_CODE) ? StPayment : StFail;
`ifdef ATP_PIN_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_d = StTimeout;
`endif
                end
            end
            StPayment: begin
                if (card_rise) begin
                    state_d = StReadCard;
                end else if (paid_done) begin
                    state_d = StSuccess;
                end else if (!edge_seen && timeout_hit) begin
                    state_d = StTimeout;
                end
            end
            StSuccess, StFail, StTimeout: begin
                if (card_inserted) state_d = StReadCard;
            end
            default: state_d = StIdle;
        endcase
    end

    // Every new transaction (or abort) starts from an empty total.
    assign clear_paid = (state_d != state_q) &&
                        ((state_d == StPayment) || (state_d == StReadCard));

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == StPayment) begin
            if (edge_seen) begin
                cnt_d = '0;
            end else if (!timeout_hit) begin
                cnt_d = cnt_q + CntW'(1);
            end
`ifdef ATP_PIN_TIMEOUT_EN
        end else if (state_q == StPinEntry) begin
            if (!timeout_hit) cnt_d = cnt_q + CntW'(1);
`endif
        end
    end

    always_comb begin
        card_id_d = card_id_q;
        if (state_d == StReadCard && card_inserted) card_id_d = card_data;
    end

    always_comb begin
        display_d = 8'd0;
        unique case (state_d)
            StIdle:                         display_d = 8'd0;
            StReadCard, StPinEntry, StFail: display_d = card_id_d;
            StPayment, StSuccess, StTimeout: display_d = paid_next;
            default:                        display_d = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            card_id_q   <= 8'd0;
            card_prev_q <= 1'b0;
            cnt_q       <= '0;
            display_q   <= 8'd0;
            success_q   <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            card_id_q   <= card_id_d;
            card_prev_q <= card_inserted;
            cnt_q       <= cnt_d;
            display_q   <= display_d;
            success_q   <= (state_d == StSuccess);
            fail_q      <= (state_d == StFail);
            timeout_q   <= (state_d == StTimeout);
        end
    end

    assign display         = display_q;
    assign payment_success = success_q;
    assign payment_fail    = fail_q;
    assign payment_timeout = timeout_q;

endmodule

// File: tb/tb_atp_machine_electricity_bill_payment.sv
// Directed bench for the bill-payment kiosk; a second instance with a 255-unit bill checks saturation.
module tb_atp_machine_electricity_bill_payment;

    logic       clk;
    logic       reset;
    logic       card_inserted;
    logic [7:0] card_data;
    logic [3:0] pin;
    logic       p1000, p500, p100, p50;
    logic [7:0] display, display_sat;
    logic       succ, fail, tmo;
    logic       succ_sat, fail_sat, tmo_sat;
    logic [7:0] flags, flags_sat;

    int checks = 0;
    int errors = 0;

    assign flags     = {5'b0, succ, fail, tmo};
    assign flags_sat = {5'b0, succ_sat, fail_sat, tmo_sat};

    atp_machine_electricity_bill_payment dut (
        .clk             (clk),
        .reset           (reset),
        .card_inserted   (card_inserted),
        .card_data       (card_data),
        .pin             (pin),
        .payment_1000    (p1000),
        .payment_500     (p500),
        .payment_100     (p100),
        .payment_50      (p50),
        .display         (display),
        .payment_success (succ),
        .payment_fail    (fail),
        .payment_timeout (tmo)
    );

    atp_machine_electricity_bill_payment #(
        .BILL_UNITS (255)
    ) dut_sat (
        .clk             (clk),
        .reset           (reset),
        .card_inserted   (card_inserted),
        .card_data       (card_data),
        .pin             (pin),
        .payment_1000    (p1000),
        .payment_500     (p500),
        .payment_100     (p100),
        .payment_50      (p50),
        .display         (display_sat),
        .payment_success (succ_sat),
        .payment_fail    (fail_sat),
        .payment_timeout (tmo_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    // Card in for one cycle, card out, then PIN; leaves DUT in PIN result state.
    task automatic start_txn(input logic [7:0] id, input logic [3:0] code);
        card_inserted = 1'b1; card_data = id; tick();
        card_inserted = 1'b0; tick();
        pin = code; tick();
        pin = 4'd0;
    endtask

    initial begin
        reset = 1'b1; card_inserted = 1'b0; card_data = 8'h00; pin = 4'd0;
        p1000 = 1'b0; p500 = 1'b0; p100 = 1'b0; p50 = 1'b0;
        tick(); tick();
        chk("reset_display", display, 8'h00);
        chk("reset_flags", flags, 8'h00);
        reset = 1'b0;

        // Success with one note per cycle
        card_inserted = 1'b1; card_data = 8'hAB; tick();
        chk("read_card_display", display, 8'hAB);
        card_inserted = 1'b0; tick();
        chk("pin_entry_display", display, 8'hAB);
        pin = 4'b1010; tick(); pin = 4'd0;
        chk("payment_entry_display", display, 8'd0);
        p1000 = 1'b1; tick();
        chk("paid_20", display, 8'd20);
        p500 = 1'b1; tick();
        chk("paid_30", display, 8'd30);
        p100 = 1'b1; tick();
        chk("paid_32", display, 8'd32);
        p50 = 1'b1; tick();
        chk("paid_33", display, 8'd33);
        chk("flags_before_success", flags, 8'h00);
        tick();
        chk("success_flag", flags, 8'h04);
        chk("success_display", display, 8'd33);
        p1000 = 1'b0; p500 = 1'b0; p100 = 1'b0; p50 = 1'b0;

        // Wrong PIN
        start_txn(8'hCD, 4'b0101);
        chk("fail_flag", flags, 8'h02);
        chk("fail_display", display, 8'hCD);
        p1000 = 1'b1; tick(); p1000 = 1'b0;
        chk("fail_ignores_notes", display, 8'hCD);
        chk("fail_flag_held", flags, 8'h02);

        // Payment timeout
        start_txn(8'hEF, 4'b1010);
        chk("timeout_entry_flags", flags, 8'h00);
        tick(); tick(); tick(); tick();
        chk("timeout_not_yet", flags, 8'h00);
        tick();
        chk("timeout_flag", flags, 8'h01);
        chk("timeout_display", display, 8'd0);

        // Four simultaneous notes
        start_txn(8'h11, 4'b1010);
        p1000 = 1'b1; p500 = 1'b1; p100 = 1'b1; p50 = 1'b1; tick();
        chk("simultaneous_paid", display, 8'd33);
        tick();
        chk("simultaneous_success", flags, 8'h04);
        p1000 = 1'b0; p500 = 1'b0; p100 = 1'b0; p50 = 1'b0;

        // Reset mid-payment
        start_txn(8'h22, 4'b1010);
        p1000 = 1'b1; tick(); p1000 = 1'b0;
        p500 = 1'b1; tick();
        chk("pre_reset_paid", display, 8'd30);
        reset = 1'b1; p500 = 1'b0; tick();
        chk("reset_mid_display", display, 8'h00);
        chk("reset_mid_flags", flags, 8'h00);
        reset = 1'b0; tick();

        // Abort by new card during payment
        start_txn(8'h33, 4'b1010);
        p100 = 1'b1; tick(); p100 = 1'b0;
        chk("abort_pre_paid", display, 8'd2);
        card_inserted = 1'b1; card_data = 8'h44; tick();
        chk("abort_read_card", display, 8'h44);
        card_inserted = 1'b0; tick();
        pin = 4'b1010; tick(); pin = 4'd0;
        chk("abort_paid_cleared", display, 8'd0);
        chk("abort_flags", flags, 8'h00);
        tick(); tick(); tick(); tick(); tick();
        chk("abort_then_timeout", flags, 8'h01);

        // PIN left blank after card removal
        card_inserted = 1'b1; card_data = 8'h55; tick();
        card_inserted = 1'b0; tick();
        tick(); tick(); tick(); tick();
        chk("pin_idle_no_flag_yet", flags, 8'h00);
        tick();
`ifdef ATP_PIN_TIMEOUT_EN
        chk("pin_idle_timeout", flags, 8'h01);
        chk("pin_idle_display", display, 8'd0);
`else
        chk("pin_idle_no_flag", flags, 8'h00);
        chk("pin_idle_display", display, 8'h55);
`endif

        // Saturation with a 255-unit bill
        reset = 1'b1; tick(); reset = 1'b0;
        start_txn(8'h66, 4'b1010);
        for (int i = 1; i <= 13; i++) begin
            p1000 = 1'b1; tick();
            if (i == 12) chk("sat_paid_240", display_sat, 8'd240);
            p1000 = 1'b0; tick();
        end
        chk("sat_paid_clamp", display_sat, 8'd255);
        chk("sat_success", flags_sat, 8'h04);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
